// File: rtl/ctrl_pkg.sv
// Shared decode constants, control-slice payload and decode helpers for the ID/EX control unit.
package ctrl_pkg;

    localparam int unsigned EXE_W = 4;

    localparam logic [1:0] MODE_ARITH  = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;
    localparam logic [1:0] MODE_BLOCK  = 2'b11;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    localparam logic [EXE_W-1:0] MOV_EXE = 4'b0001;
    localparam logic [EXE_W-1:0] MVN_EXE = 4'b1001;
    localparam logic [EXE_W-1:0] ADD_EXE = 4'b0010;
    localparam logic [EXE_W-1:0] ADC_EXE = 4'b0011;
    localparam logic [EXE_W-1:0] SUB_EXE = 4'b0100;
    localparam logic [EXE_W-1:0] SBC_EXE = 4'b0101;
    localparam logic [EXE_W-1:0] AND_EXE = 4'b0110;
    localparam logic [EXE_W-1:0] ORR_EXE = 4'b0111;
    localparam logic [EXE_W-1:0] EOR_EXE = 4'b1000;
    localparam logic [EXE_W-1:0] CMP_EXE = 4'b0100;
    localparam logic [EXE_W-1:0] TST_EXE = 4'b0110;
    localparam logic [EXE_W-1:0] LDR_EXE = 4'b0010;
    localparam logic [EXE_W-1:0] STR_EXE = 4'b0010;

    localparam logic S_LDR = 1'b1;
    localparam logic S_STR = 1'b0;

    typedef enum logic {ST_IDLE, ST_BLOCK} state_t;

    typedef struct packed {
        logic [EXE_W-1:0] exe_cmd;
        logic             mem_read;
        logic             mem_write;
        logic             wb_enable;
        logic             branch_taken;
        logic             status_write_enable;
        logic             valid;
        logic             last_beat;
    } ctrl_t;

    // Data-processing decode; unlisted opcodes come back as an all-zero bubble.
    function automatic ctrl_t decode_arith(input logic [3:0] opcode, input logic s);
        ctrl_t c;
        c                     = '0;
        c.valid               = 1'b1;
        c.wb_enable           = 1'b1;
        c.status_write_enable = s;
        case (opcode)
            OP_MOV: c.exe_cmd = MOV_EXE;
            OP_MVN: c.exe_cmd = MVN_EXE;
            OP_ADD: c.exe_cmd = ADD_EXE;
            OP_ADC: c.exe_cmd = ADC_EXE;
            OP_SUB: c.exe_cmd = SUB_EXE;
            OP_SBC: c.exe_cmd = SBC_EXE;
            OP_AND: c.exe_cmd = AND_EXE;
            OP_ORR: c.exe_cmd = ORR_EXE;
            OP_EOR: c.exe_cmd = EOR_EXE;
            OP_CMP: begin
                c.exe_cmd             = CMP_EXE;
                c.wb_enable           = 1'b0;
                c.status_write_enable = 1'b1;
            end
            OP_TST: begin
                c.exe_cmd             = TST_EXE;
                c.wb_enable           = 1'b0;
                c.status_write_enable = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // One load/store beat; single memory ops and block beats share this shape.
    function automatic ctrl_t mem_beat(input logic s, input logic last);
        ctrl_t c;
        c           = '0;
        c.valid     = 1'b1;
        c.exe_cmd   = (s == S_LDR) ? LDR_EXE : STR_EXE;
        c.mem_read  = (s == S_LDR);
        c.mem_write = (s == S_STR);
        c.wb_enable = (s == S_LDR);
        c.last_beat = last;
        return c;
    endfunction

endpackage

// File: rtl/block_ctrl_unit_if.sv
// Decode-side inputs and ID/EX control-slice outputs of block_ctrl_unit.
interface block_ctrl_unit_if #(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned EXE_CMD_W = 4
);
    localparam int unsigned BEAT_W = $clog2(MAX_BEATS);

    logic                 instr_valid;
    logic [1:0]           mode;
    logic [3:0]           opcode;
    logic                 s;
    logic                 cond_pass;
    logic [MAX_BEATS-1:0] reg_list;
    logic                 hazard;
    logic                 flush;

    logic [EXE_CMD_W-1:0] exe_cmd;
    logic                 mem_read;
    logic                 mem_write;
    logic                 wb_enable;
    logic                 branch_taken;
    logic                 status_write_enable;
    logic                 valid_out;
    logic [BEAT_W-1:0]    beat_reg;
    logic [BEAT_W+1:0]    beat_offset;
    logic                 last_beat;
    logic                 stall_out;

    modport master (
        output instr_valid, mode, opcode, s, cond_pass, reg_list, hazard, flush,
        input  exe_cmd, mem_read, mem_write, wb_enable, branch_taken, status_write_enable,
        input  valid_out, beat_reg, beat_offset, last_beat, stall_out
    );

    modport slave (
        input  instr_valid, mode, opcode, s, cond_pass, reg_list, hazard, flush,
        output exe_cmd, mem_read, mem_write, wb_enable, branch_taken, status_write_enable,
        output valid_out, beat_reg, beat_offset, last_beat, stall_out
    );
endinterface

// File: rtl/lsb_finder.sv
// Lowest-set-bit encoder with "any bit" and "more than one bit" flags.
module lsb_finder #(
    parameter int unsigned W  = 16,
    parameter int unsigned IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx_c,
    output logic          found_c,
    output logic          multi_c
);

    // Scan high to low so the last hit wins and leaves the lowest index.
    always_comb begin
        idx_c = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx_c = IW'(i);
        end
    end

    assign found_c = |vec;
    assign multi_c = |(vec & (vec - W'(1)));

endmodule

// File: rtl/block_ctrl_unit.sv
// Registered ID/EX control decode with squash/bubble/flush and LDM/STM beat sequencing.
module block_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned EXE_CMD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    block_ctrl_unit_if.slave  bus
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS);

    state_t               state, state_n;
    logic [MAX_BEATS-1:0] remaining, remaining_n;
    logic                 blk_s, blk_s_n;
    logic [BEAT_W-1:0]    beat_cnt, beat_cnt_n;

    ctrl_t                slice_q, slice_n;
    logic [BEAT_W-1:0]    beat_reg_q, beat_reg_n;
    logic [BEAT_W+1:0]    beat_off_q, beat_off_n;
    logic                 stall;

    logic [MAX_BEATS-1:0] fin_vec;
    logic [BEAT_W-1:0]    fin_idx;
    logic                 fin_found;
    logic                 fin_multi;
    logic                 accept;

    // In BLOCK the latched list drives beat selection; in IDLE the incoming list does.
    assign fin_vec = (state == ST_BLOCK) ? remaining : bus.reg_list;
    assign accept  = bus.instr_valid & bus.cond_pass & ~bus.hazard & ~bus.flush;

    lsb_finder #(.W(MAX_BEATS), .IW(BEAT_W)) u_lsb (
        .vec     (fin_vec),
        .idx_c   (fin_idx),
        .found_c (fin_found),
        .multi_c (fin_multi)
    );

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        blk_s_n     = blk_s;
        beat_cnt_n  = beat_cnt;
        slice_n     = '0;
        beat_reg_n  = '0;
        beat_off_n  = '0;
        stall       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.mode)
                        MODE_ARITH: slice_n = decode_arith(bus.opcode, bus.s);
                        MODE_MEM:   slice_n = mem_beat(bus.s, 1'b1);
                        MODE_BRANCH: begin
                            slice_n.branch_taken = 1'b1;
                            slice_n.valid        = 1'b1;
                        end
                        MODE_BLOCK: begin
                            if (fin_found) begin
                                slice_n    = mem_beat(bus.s, ~fin_multi);
                                beat_reg_n = fin_idx;
                                if (fin_multi) begin
                                    stall       = 1'b1;
                                    state_n     = ST_BLOCK;
                                    remaining_n = bus.reg_list & ~(MAX_BEATS'(1) << fin_idx);
                                    blk_s_n     = bus.s;
                                    beat_cnt_n  = BEAT_W'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BLOCK: begin
                stall = fin_multi;
                if (bus.flush) begin
                    state_n     = ST_IDLE;
                    remaining_n = '0;
                    beat_cnt_n  = '0;
                end else if (!bus.hazard) begin
                    slice_n     = mem_beat(blk_s, ~fin_multi);
                    beat_reg_n  = fin_idx;
                    beat_off_n  = {beat_cnt, 2'b00};
                    remaining_n = remaining & ~(MAX_BEATS'(1) << fin_idx);
                    if (fin_multi) begin
                        beat_cnt_n = beat_cnt + BEAT_W'(1);
                    end else begin
                        beat_cnt_n = '0;
                        state_n    = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            blk_s      <= 1'b0;
            beat_cnt   <= '0;
            slice_q    <= '0;
            beat_reg_q <= '0;
            beat_off_q <= '0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            blk_s      <= blk_s_n;
            beat_cnt   <= beat_cnt_n;
            slice_q    <= slice_n;
            beat_reg_q <= beat_reg_n;
            beat_off_q <= beat_off_n;
        end
    end

    assign bus.exe_cmd             = EXE_CMD_W'(slice_q.exe_cmd);
    assign bus.mem_read            = slice_q.mem_read;
    assign bus.mem_write           = slice_q.mem_write;
    assign bus.wb_enable           = slice_q.wb_enable;
    assign bus.branch_taken        = slice_q.branch_taken;
    assign bus.status_write_enable = slice_q.status_write_enable;
    assign bus.valid_out           = slice_q.valid;
    assign bus.last_beat           = slice_q.last_beat;
    assign bus.beat_reg            = beat_reg_q;
    assign bus.beat_offset         = beat_off_q;
    assign bus.stall_out           = stall;

endmodule

// File: tb/tb_block_ctrl_unit.sv
// Self-checking bench for block_ctrl_unit: directed scenarios plus random traffic against a queue-based model.
module tb_block_ctrl_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_ctrl_unit_if #(.MAX_BEATS(16), .EXE_CMD_W(4)) bus ();

    block_ctrl_unit #(.MAX_BEATS(16), .EXE_CMD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pend[$];
    int   beat_num = 0;
    logic blk_s_m  = 1'b0;
    int   obs_reg[$];
    int   obs_off[$];
    int   obs_last[$];
    int   stall_hi = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed view: {exe_cmd, mem_read, mem_write, wb_enable, branch_taken, swe, valid, beat_reg, beat_offset, last_beat}
    function automatic logic [20:0] beat_vec(input logic s, input int r, input int num, input logic last);
        logic [3:0] rr;
        logic [5:0] off;
        rr  = 4'(r);
        off = 6'(num * 4);
        return {4'b0010, s, ~s, s, 1'b0, 1'b0, 1'b1, rr, off, last};
    endfunction

    function automatic logic [20:0] arith_vec(input logic [3:0] op, input logic s);
        logic [3:0] e;
        logic       wb, swe, ok;
        ok = 1'b1; wb = 1'b1; swe = s; e = 4'h0;
        case (op)
            4'b1101: e = 4'b0001;
            4'b1111: e = 4'b1001;
            4'b0100: e = 4'b0010;
            4'b0101: e = 4'b0011;
            4'b0010: e = 4'b0100;
            4'b0110: e = 4'b0101;
            4'b0000: e = 4'b0110;
            4'b1100: e = 4'b0111;
            4'b0001: e = 4'b1000;
            4'b1010: begin e = 4'b0100; wb = 1'b0; swe = 1'b1; end
            4'b1000: begin e = 4'b0110; wb = 1'b0; swe = 1'b1; end
            default: ok = 1'b0;
        endcase
        if (!ok) return '0;
        return {e, 1'b0, 1'b0, wb, 1'b0, swe, 1'b1, 4'h0, 6'h0, 1'b0};
    endfunction

    function automatic logic [20:0] slice_obs();
        return {bus.exe_cmd, bus.mem_read, bus.mem_write, bus.wb_enable, bus.branch_taken,
                bus.status_write_enable, bus.valid_out, bus.beat_reg, bus.beat_offset, bus.last_beat};
    endfunction

    task automatic set_in(input logic iv, input logic [1:0] md, input logic [3:0] op, input logic sb,
                          input logic cp, input logic [15:0] rl, input logic hz, input logic fl);
        bus.instr_valid = iv; bus.mode = md; bus.opcode = op; bus.s = sb;
        bus.cond_pass = cp; bus.reg_list = rl; bus.hazard = hz; bus.flush = fl;
    endtask

    // One clock: predict from the model, check stall mid-cycle, check the slice after the edge.
    task automatic step();
        logic [20:0] exp;
        logic        exp_stall;
        int          list[$];
        int          r;
        #1;
        exp = '0;
        exp_stall = 1'b0;
        if (pend.size() > 0) begin
            exp_stall = (pend.size() >= 2);
            if (bus.flush) begin
                pend.delete();
                beat_num = 0;
            end else if (!bus.hazard) begin
                r = pend.pop_front();
                exp = beat_vec(blk_s_m, r, beat_num, pend.size() == 0);
                beat_num = (pend.size() == 0) ? 0 : beat_num + 1;
            end
        end else if (bus.instr_valid && bus.cond_pass && !bus.hazard && !bus.flush) begin
            case (bus.mode)
                2'b00: exp = arith_vec(bus.opcode, bus.s);
                2'b01: exp = beat_vec(bus.s, 0, 0, 1'b1);
                2'b10: exp = {4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 6'h0, 1'b0};
                default: begin
                    for (int i = 0; i < 16; i++) if (bus.reg_list[i]) list.push_back(i);
                    if (list.size() > 0) begin
                        exp_stall = (list.size() >= 2);
                        exp = beat_vec(bus.s, list[0], 0, list.size() == 1);
                        for (int i = 1; i < list.size(); i++) pend.push_back(list[i]);
                        beat_num = 1;
                        blk_s_m  = bus.s;
                    end
                end
            endcase
        end
        if (rst) begin
            exp = '0;
            pend.delete();
            beat_num = 0;
        end
        if (bus.stall_out) stall_hi++;
        check("stall_out", 32'(bus.stall_out), 32'(exp_stall));
        @(posedge clk);
        #1;
        check("slice", 32'(slice_obs()), 32'(exp));
        obs_reg.push_back(int'(bus.beat_reg));
        obs_off.push_back(int'(bus.beat_offset));
        obs_last.push_back(int'(bus.last_beat));
    endtask

    task automatic clear_obs();
        obs_reg.delete(); obs_off.delete(); obs_last.delete(); stall_hi = 0;
    endtask

    initial begin
        int exp_r[4];
        exp_r = '{0, 2, 5, 15};
        rst = 1'b1;
        set_in(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        step();
        check("rst_valid", 32'(bus.valid_out), 32'h0);
        rst = 1'b0;

        // ADD with S, then CMP squashed, then TST
        set_in(1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0); step();
        check("add_exe", 32'(bus.exe_cmd), 32'h2);
        set_in(1'b1, 2'b00, 4'b1010, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0); step();
        set_in(1'b1, 2'b00, 4'b1000, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0); step();
        check("tst_exe", 32'(bus.exe_cmd), 32'h6);
        set_in(1'b1, 2'b00, 4'b0011, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0); step();
        set_in(1'b1, 2'b01, 4'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0); step();
        set_in(1'b1, 2'b10, 4'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0); step();

        // Block load 0x8025: four beats, stall for three cycles
        clear_obs();
        set_in(1'b1, 2'b11, 4'h0, 1'b1, 1'b1, 16'h8025, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 4; k++) check("blk_reg", 32'(obs_reg[k]), 32'(exp_r[k]));
        check("blk_last", 32'(obs_last[3]), 32'h1);
        check("blk_stall_cnt", 32'(stall_hi), 32'd3);

        // Block store 0x0006 with a hazard on the second beat cycle
        set_in(1'b1, 2'b11, 4'h0, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b0); step();
        bus.hazard = 1'b1; step();
        bus.hazard = 1'b0; step();
        check("haz_last", 32'(bus.last_beat), 32'h1);

        // Block load 0x00FF flushed on its third beat
        set_in(1'b1, 2'b11, 4'h0, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0); step(); step();
        bus.flush = 1'b1; step();
        set_in(1'b0, 2'b11, 4'h0, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0); step(); step();

        // Empty list, then reset mid-transfer
        set_in(1'b1, 2'b11, 4'h0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0); step();
        set_in(1'b1, 2'b11, 4'h0, 1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0); step(); step();
        rst = 1'b1; step();
        rst = 1'b0; set_in(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0); step();

        // Full list: offset must reach 60 without wrapping
        clear_obs();
        set_in(1'b1, 2'b11, 4'h0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) step();
        check("full_off", 32'(obs_off[15]), 32'd60);
        check("full_last", 32'(obs_last[15]), 32'h1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            logic [15:0] rl;
            case ($urandom_range(0, 3))
                0: rl = 16'h0;
                1: rl = 16'(1) << $urandom_range(0, 15);
                2: rl = 16'($urandom);
                default: rl = 16'($urandom) & 16'($urandom);
            endcase
            rst = ($urandom_range(0, 49) == 0);
            set_in($urandom_range(0, 7) != 0, 2'($urandom), 4'($urandom), 1'($urandom),
                   $urandom_range(0, 3) != 0, rl, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 15) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
